// File: rtl/qspi_flash_responder_pkg.sv
// Shared definitions for the QSPI flash responder: FSM encodings, default
// opcode and the order in which a byte's nibbles go out on io[3:0].
package qspi_flash_responder_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE   = 3'd0;
  localparam state_t ST_CMD    = 3'd1;
  localparam state_t ST_ADDR   = 3'd2;
  localparam state_t ST_DUMMY  = 3'd3;
  localparam state_t ST_DATA   = 3'd4;
  localparam state_t ST_IGNORE = 3'd5;

  localparam logic [7:0] CMD_READ_DEFAULT = 8'h6B;

  localparam bit HI_NIBBLE_FIRST = 1'b1;

  // Picks the nibble sent first (first=1) or second (first=0) for a byte.
  function automatic logic [3:0] pick_nibble(input logic [7:0] b, input logic first);
    return (first == HI_NIBBLE_FIRST) ? b[7:4] : b[3:0];
  endfunction

endpackage

// File: rtl/qspi_flash_responder_if.sv
// Bundle of the QSPI link pins and the byte-wide read port seen by the
// responder. The slave modport is the flash side, master is initiator + memory.
interface qspi_flash_responder_if #(
  parameter int ADDR_BITS = 24
);
  import qspi_flash_responder_pkg::*;

  logic                 spi_clk;
  logic                 spi_cs;
  logic                 spi_mosi;
  logic [3:0]           spi_miso;
  logic                 spi_oe;
  logic                 rd_req;
  logic [ADDR_BITS-1:0] rd_addr;
  logic                 rd_valid;
  logic [7:0]           rd_data;
  logic                 underrun;

  // Read port handshake: rd_req is a single-cycle request qualified by rd_addr;
  // the memory answers each request, in order, with one rd_valid cycle carrying
  // rd_data after any latency. There is no backpressure in either direction.
  modport slave (
    input  spi_clk, spi_cs, spi_mosi, rd_valid, rd_data,
    output spi_miso, spi_oe, rd_req, rd_addr, underrun
  );

  modport master (
    output spi_clk, spi_cs, spi_mosi, rd_valid, rd_data,
    input  spi_miso, spi_oe, rd_req, rd_addr, underrun
  );

endinterface

// File: rtl/qspi_flash_responder_spi_sync_edge.sv
// Brings the asynchronous SPI pins into the clk domain and flags spi_clk edges.
// All three pins see the same two-flop delay so mosi lines up with its rise.
module spi_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic spi_clk,
  input  logic spi_cs,
  input  logic spi_mosi,
  output logic sclk_rise,
  output logic sclk_fall,
  output logic cs_n,
  output logic mosi
);

  logic [1:0] sclk_sync;
  logic [1:0] cs_sync;
  logic [1:0] mosi_sync;
  logic       sclk_prev;

  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_sync <= 2'b00;
      cs_sync   <= 2'b11;
      mosi_sync <= 2'b00;
      sclk_prev <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[0], spi_clk};
      cs_sync   <= {cs_sync[0], spi_cs};
      mosi_sync <= {mosi_sync[0], spi_mosi};
      sclk_prev <= sclk_sync[1];
    end
  end

  assign sclk_rise = sclk_sync[1] & ~sclk_prev;
  assign sclk_fall = ~sclk_sync[1] & sclk_prev;
  assign cs_n      = cs_sync[1];
  assign mosi      = mosi_sync[1];

endmodule

// File: rtl/qspi_flash_responder.sv
// Flash side of a quad-output fast read: decodes opcode and address on io0,
// counts dummy clocks, then streams prefetched bytes as nibbles on io[3:0].
module qspi_flash_responder
  import qspi_flash_responder_pkg::*;
#(
  parameter logic [7:0] CMD_READ     = CMD_READ_DEFAULT,
  parameter int         ADDR_BITS    = 24,
  parameter int         DUMMY_CYCLES = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  qspi_flash_responder_if.slave bus,
  output state_t                state_dbg
);

  localparam int CNT_W = $clog2(((ADDR_BITS > 8) ? ADDR_BITS : 8) + 1);
  localparam int DUM_W = $clog2(DUMMY_CYCLES + 2);
  localparam logic [CNT_W-1:0] CMD_LAST  = CNT_W'(7);
  localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_BITS - 1);
  localparam logic [DUM_W-1:0] DUM_LAST  = DUM_W'(DUMMY_CYCLES);

  logic sclk_rise, sclk_fall, cs_n, mosi;

  spi_sync_edge u_sync (
    .clk       (clk),
    .rst       (rst),
    .spi_clk   (bus.spi_clk),
    .spi_cs    (bus.spi_cs),
    .spi_mosi  (bus.spi_mosi),
    .sclk_rise (sclk_rise),
    .sclk_fall (sclk_fall),
    .cs_n      (cs_n),
    .mosi      (mosi)
  );

  state_t               state;
  logic [CNT_W-1:0]     bit_cnt;
  logic [DUM_W-1:0]     dummy_cnt;
  logic [6:0]           cmd_sr;
  logic [ADDR_BITS-2:0] addr_sr;
  logic [ADDR_BITS-1:0] addr;
  logic [7:0]           buf_data;
  logic                 buf_valid;
  logic                 slot_miss;
  logic                 nib_first;
  logic [2:0]           out_cnt;
  logic [2:0]           drop_cnt;

  logic [7:0]           cmd_word;
  logic [ADDR_BITS-1:0] addr_word;
  logic [ADDR_BITS-1:0] addr_next;
  logic                 addr_done;
  logic                 accept, keep, drive_nib, consume, slot_arrived, issue_req;
  logic [3:0]           nib_val;
  logic                 nib_miss;

  assign cmd_word  = {cmd_sr, mosi};
  assign addr_word = {addr_sr, mosi};
  assign addr_next = addr + ADDR_BITS'(1);
  assign addr_done = !cs_n && state == ST_ADDR && sclk_rise && bit_cnt == ADDR_LAST;

  // Responses only land while a read is live; drop_cnt counts responses that
  // belong to slots already given up on, so they never fill a later slot.
  assign accept       = !cs_n && (state == ST_DUMMY || state == ST_DATA)
                        && bus.rd_valid && out_cnt != 3'd0;
  assign keep         = accept && drop_cnt == 3'd0;
  assign drive_nib    = !cs_n && sclk_fall
                        && ((state == ST_DUMMY && dummy_cnt == DUM_LAST) || state == ST_DATA);
  assign consume      = drive_nib && !nib_first;
  assign slot_arrived = buf_valid || keep;
  assign issue_req    = addr_done || consume;

  always_comb begin
    nib_val  = 4'hF;
    nib_miss = 1'b0;
    if (nib_first) begin
      if (buf_valid) nib_val = pick_nibble(buf_data, 1'b1);
      else           nib_miss = 1'b1;
    end else if (slot_miss || !buf_valid) begin
      nib_miss = 1'b1;
    end else begin
      nib_val = pick_nibble(buf_data, 1'b0);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      bit_cnt      <= '0;
      dummy_cnt    <= '0;
      cmd_sr       <= '0;
      addr_sr      <= '0;
      addr         <= '0;
      buf_data     <= '0;
      buf_valid    <= 1'b0;
      slot_miss    <= 1'b0;
      nib_first    <= 1'b1;
      out_cnt      <= '0;
      drop_cnt     <= '0;
      bus.spi_miso <= 4'h0;
      bus.spi_oe   <= 1'b0;
      bus.rd_req   <= 1'b0;
      bus.rd_addr  <= '0;
      bus.underrun <= 1'b0;
    end else begin
      bus.rd_req <= issue_req;
      if (cs_n) begin
        // Deselect wins over any edge seen in the same cycle.
        state        <= ST_IDLE;
        bit_cnt      <= '0;
        dummy_cnt    <= '0;
        buf_valid    <= 1'b0;
        slot_miss    <= 1'b0;
        nib_first    <= 1'b1;
        out_cnt      <= '0;
        drop_cnt     <= '0;
        bus.spi_miso <= 4'h0;
        bus.spi_oe   <= 1'b0;
      end else begin
        if (consume) begin
          buf_valid <= 1'b0;
        end else if (keep) begin
          buf_valid <= 1'b1;
          buf_data  <= bus.rd_data;
        end
        out_cnt  <= out_cnt + 3'(issue_req) - 3'(accept);
        drop_cnt <= drop_cnt + 3'(consume && !slot_arrived) - 3'(accept && !keep);

        if (drive_nib) begin
          bus.spi_miso <= nib_val;
          bus.spi_oe   <= 1'b1;
          nib_first    <= !nib_first;
          if (nib_first) slot_miss <= nib_miss;
          if (nib_miss) bus.underrun <= 1'b1;
        end

        case (state)
          ST_IDLE: state <= ST_CMD;
          ST_CMD: begin
            if (sclk_rise) begin
              cmd_sr <= cmd_word[6:0];
              if (bit_cnt == CMD_LAST) begin
                bit_cnt <= '0;
                state   <= (cmd_word == CMD_READ) ? ST_ADDR : ST_IGNORE;
              end else begin
                bit_cnt <= bit_cnt + CNT_W'(1);
              end
            end
          end
          ST_ADDR: begin
            if (sclk_rise) begin
              addr_sr <= addr_word[ADDR_BITS-2:0];
              if (addr_done) begin
                bit_cnt     <= '0;
                dummy_cnt   <= '0;
                addr        <= addr_word;
                bus.rd_addr <= addr_word;
                state       <= ST_DUMMY;
              end else begin
                bit_cnt <= bit_cnt + CNT_W'(1);
              end
            end
          end
          ST_DUMMY: begin
            if (sclk_rise && dummy_cnt != DUM_LAST) dummy_cnt <= dummy_cnt + DUM_W'(1);
            if (drive_nib) state <= ST_DATA;
          end
          ST_DATA: begin
            if (consume) begin
              addr        <= addr_next;
              bus.rd_addr <= addr_next;
            end
          end
          ST_IGNORE: state <= ST_IGNORE;
          default:   state <= ST_IDLE;
        endcase
      end
    end
  end

  assign state_dbg = state;

endmodule

// File: tb/tb_qspi_flash_responder.sv
// Bench for qspi_flash_responder: drives the initiator side of the link, models
// a latency-programmable byte memory returning addr[7:0], and scoreboards both.
module tb_qspi_flash_responder;
  import qspi_flash_responder_pkg::*;

  localparam int AB   = 24;
  localparam int HALF = 40;  // spi_clk half period: 4 clk

  // ---------------- clock / reset ----------------
  logic   clk = 1'b0;
  logic   rst;
  state_t state_dbg;

  always #5 clk = ~clk;

  qspi_flash_responder_if #(.ADDR_BITS(AB)) bus ();

  qspi_flash_responder #(.ADDR_BITS(AB)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_err = 0;
  logic [7:0]    exp_q[$];
  logic [AB-1:0] addr_q[$];

  typedef struct {
    logic [7:0] data;
    int         due;
  } resp_t;
  resp_t resp_q[$];
  int    rd_lat = 2;
  int    cyc    = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Memory model: every rd_req is checked against the expected address and
  // answered with addr[7:0] rd_lat cycles later.
  initial begin
    bus.rd_valid = 1'b0;
    bus.rd_data  = 8'h00;
    forever begin
      @(negedge clk);
      cyc++;
      if (bus.rd_req === 1'b1) begin
        resp_q.push_back('{bus.rd_addr[7:0], cyc + rd_lat});
        if (addr_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL rd_req_unexpected: got addr %0h expected none", bus.rd_addr);
        end else begin
          check("rd_addr", 32'(bus.rd_addr), 32'(addr_q.pop_front()));
        end
      end
      bus.rd_valid = 1'b0;
      if (resp_q.size() != 0 && resp_q[0].due <= cyc) begin
        bus.rd_valid = 1'b1;
        bus.rd_data  = resp_q[0].data;
        void'(resp_q.pop_front());
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- driver tasks ----------------
  task automatic pulse(input logic mosi_v, output logic [3:0] nib, output logic oe);
    bus.spi_mosi = mosi_v;
    #(HALF);
    nib = bus.spi_miso;
    oe  = bus.spi_oe;
    bus.spi_clk = 1'b1;
    #(HALF);
    bus.spi_clk = 1'b0;
  endtask

  task automatic send_header(input logic [7:0] cmd, input logic [AB-1:0] a, input int nbits);
    logic [3:0] nib;
    logic       oe;
    bus.spi_cs = 1'b0;
    #(HALF);
    for (int i = 7; i >= 0; i--) pulse(cmd[i], nib, oe);
    for (int i = 0; i < nbits; i++) pulse(a[AB-1-i], nib, oe);
  endtask

  task automatic dummy_clocks();
    logic [3:0] nib;
    logic       oe;
    for (int i = 0; i < 8; i++) pulse(1'b0, nib, oe);
  endtask

  task automatic read_bytes(input int n);
    logic [3:0] hi, lo;
    logic       oe_hi, oe_lo;
    logic [7:0] exp_b;
    for (int i = 0; i < n; i++) begin
      pulse(1'b0, hi, oe_hi);
      pulse(1'b0, lo, oe_lo);
      if (i == 0) check("oe_first_nibble", 32'(oe_hi), 32'(1));
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL byte_unexpected: got %02h expected none", {hi, lo});
      end else begin
        exp_b = exp_q.pop_front();
        check("byte", 32'({hi, lo}), 32'(exp_b));
      end
    end
  endtask

  task automatic deselect();
    bus.spi_cs   = 1'b1;
    bus.spi_clk  = 1'b0;
    bus.spi_mosi = 1'b0;
    #(HALF * 4);
    check("cs_high_state", 32'(state_dbg), 32'(ST_IDLE));
    check("cs_high_oe", 32'(bus.spi_oe), 32'(0));
    check("cs_high_miso", 32'(bus.spi_miso), 32'(0));
  endtask

  task automatic run_read(input logic [AB-1:0] a, input int n);
    send_header(8'h6B, a, AB);
    dummy_clocks();
    read_bytes(n);
    deselect();
    check("rd_req_count", 32'(addr_q.size()), 32'(0));
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [AB-1:0] addr;
    int            nbytes;
    int            lat;
    logic [7:0]    exp_first;
    logic [AB-1:0] exp_last_req;
  } vec_t;
  vec_t vecs[4];

  initial begin
    logic [AB-1:0] r;
    logic [3:0]    nib;
    logic          oe, oe_seen;
    logic [7:0]    op;

    bus.spi_clk  = 1'b0;
    bus.spi_cs   = 1'b1;
    bus.spi_mosi = 1'b0;
    rst = 1'b1;
    repeat (4) @(negedge clk);
    check("rst_state", 32'(state_dbg), 32'(ST_IDLE));
    check("rst_miso", 32'(bus.spi_miso), 32'(0));
    check("rst_oe", 32'(bus.spi_oe), 32'(0));
    check("rst_rd_req", 32'(bus.rd_req), 32'(0));
    check("rst_rd_addr", 32'(bus.rd_addr), 32'(0));
    check("rst_underrun", 32'(bus.underrun), 32'(0));
    rst = 1'b0;
    repeat (4) @(negedge clk);

    r = AB'($urandom_range(0, 32'hFFFFFF));
    vecs[0] = '{24'h000010, 4, 2, 8'h10, 24'h000014};
    vecs[1] = '{24'hFFFFFE, 3, 2, 8'hFE, 24'h000001};
    vecs[2] = '{24'h00ABCD, 2, 3, 8'hCD, 24'h00ABCF};
    vecs[3] = '{r, 2, $urandom_range(1, 5), r[7:0], r + AB'(2)};

    foreach (vecs[v]) begin
      rd_lat = vecs[v].lat;
      for (int i = 0; i < vecs[v].nbytes; i++) begin
        exp_q.push_back(vecs[v].exp_first + 8'(i));
        addr_q.push_back(vecs[v].addr + AB'(i));
      end
      addr_q.push_back(vecs[v].exp_last_req);
      run_read(vecs[v].addr, vecs[v].nbytes);
    end
    check("underrun_clean", 32'(bus.underrun), 32'(0));

    // Unsupported opcode: nothing driven, no fetches, back to IDLE on deselect.
    op = 8'h03;
    bus.spi_cs = 1'b0;
    #(HALF);
    for (int i = 7; i >= 0; i--) pulse(op[i], nib, oe);
    oe_seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      pulse(1'($urandom_range(0, 1)), nib, oe);
      oe_seen = oe_seen | oe;
    end
    check("ignore_state", 32'(state_dbg), 32'(ST_IGNORE));
    check("ignore_oe", 32'(oe_seen), 32'(0));
    deselect();

    // Slow memory: the dummy phase spans roughly 70 clk, so a 100 clk fetch
    // misses the first nibble; the late bytes are dropped and 0xF goes out.
    rd_lat = 100;
    exp_q.push_back(8'hFF);
    exp_q.push_back(8'hFF);
    addr_q.push_back(24'h000020);
    addr_q.push_back(24'h000021);
    addr_q.push_back(24'h000022);
    run_read(24'h000020, 2);
    check("underrun_set", 32'(bus.underrun), 32'(1));

    // Abort after the first nibble of byte 2, cs rising together with the fall.
    rd_lat = 30;
    exp_q.push_back(8'h55);
    addr_q.push_back(24'h000055);
    addr_q.push_back(24'h000056);
    send_header(8'h6B, 24'h000055, AB);
    dummy_clocks();
    read_bytes(1);
    bus.spi_mosi = 1'b0;
    #(HALF);
    nib = bus.spi_miso;
    bus.spi_clk = 1'b1;
    #(HALF);
    check("abort_hi_nibble", 32'(nib), 32'(4'hF));
    deselect();
    check("abort_rd_req_count", 32'(addr_q.size()), 32'(0));
    exp_q.push_back(8'h00);
    addr_q.push_back(24'h000100);
    addr_q.push_back(24'h000101);
    run_read(24'h000100, 1);

    // Reset in the middle of the address phase.
    check("underrun_before_rst", 32'(bus.underrun), 32'(1));
    rd_lat = 2;
    send_header(8'h6B, 24'h000200, 10);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_state", 32'(state_dbg), 32'(ST_IDLE));
    check("midrst_miso", 32'(bus.spi_miso), 32'(0));
    check("midrst_oe", 32'(bus.spi_oe), 32'(0));
    check("midrst_rd_req", 32'(bus.rd_req), 32'(0));
    check("midrst_rd_addr", 32'(bus.rd_addr), 32'(0));
    check("midrst_underrun", 32'(bus.underrun), 32'(0));
    rst = 1'b0;
    deselect();
    exp_q.push_back(8'h00);
    exp_q.push_back(8'h01);
    addr_q.push_back(24'h000200);
    addr_q.push_back(24'h000201);
    addr_q.push_back(24'h000202);
    run_read(24'h000200, 2);
    check("post_rst_underrun", 32'(bus.underrun), 32'(0));
    check("exp_q_drained", 32'(exp_q.size()), 32'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
